// File: rtl/n64_vdc_encoder.sv
`default_nettype none
// ============================================================================
// Module   : n64_vdc_encoder
// Brief    : Generates N64-style VDC video (dsync + 7-bit bus) from a 24-bit
//            RGB pixel stream. It has its own raster timing generator. Each
//            pixel takes four words: one sync word, then R, G and B.
// Options  : VDC_TEST_PATTERN_EN adds pattern_sel. It selects eight colour bars.
// Revision : 1.0 - initial release
// ============================================================================
module n64_vdc_encoder #(
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT  = 16,
  parameter int H_SYNC   = 57,
  parameter int H_TOTAL  = 773,
  parameter int V_ACTIVE = 240,
  parameter int V_FRONT  = 4,
  parameter int V_SYNC   = 3,
  parameter int V_TOTAL  = 263
) (
  input  logic        vdc_clk,
  input  logic        vdc_rst,
  input  logic [23:0] in_rgb,
  input  logic        in_valid,
`ifdef VDC_TEST_PATTERN_EN
  input  logic        pattern_sel,
`endif
  output logic        in_ready,
  output logic        vdc_dsync,
  output logic [6:0]  vdc_bus,
  output logic        sof,
  output logic        underrun
);

  localparam int HW = $clog2(H_TOTAL + 1);
  localparam int VW = $clog2(V_TOTAL + 1);

  localparam logic [HW-1:0] H_ACT_END  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SYNC_BEG = HW'(H_ACTIVE + H_FRONT);
  localparam logic [HW-1:0] H_SYNC_END = HW'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT_END  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SYNC_BEG = VW'(V_ACTIVE + V_FRONT);
  localparam logic [VW-1:0] V_SYNC_END = VW'(V_ACTIVE + V_FRONT + V_SYNC);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);

  // Reject raster geometries whose sync pulse would run past the line/frame end.
  if (H_ACTIVE + H_FRONT + H_SYNC > H_TOTAL) begin : g_bad_h_timing
    $error("n64_vdc_encoder: H_ACTIVE+H_FRONT+H_SYNC exceeds H_TOTAL");
  end
  if (V_ACTIVE + V_FRONT + V_SYNC > V_TOTAL) begin : g_bad_v_timing
    $error("n64_vdc_encoder: V_ACTIVE+V_FRONT+V_SYNC exceeds V_TOTAL");
  end

  logic [1:0]    phase;
  logic [HW-1:0] h;
  logic [VW-1:0] v;
  logic [23:0]   hold;

  logic       active;
  logic       hsync_n;
  logic       vsync_n;
  logic [6:0] sync_word;
  logic       use_pattern;
  logic [23:0] pattern_rgb;
  logic       unused_bits;

  assign active    = (h < H_ACT_END) && (v < V_ACT_END);
  assign hsync_n   = !((h >= H_SYNC_BEG) && (h < H_SYNC_END));
  assign vsync_n   = !((v >= V_SYNC_BEG) && (v < V_SYNC_END));
  assign sync_word = {3'b000, vsync_n, 1'b1, hsync_n, hsync_n & vsync_n};

`ifdef VDC_TEST_PATTERN_EN
  localparam logic [HW-1:0] BAR_W = HW'(H_ACTIVE / 8);
  logic [HW-1:0] bar_full;
  logic [2:0]    bar;
  logic          pattern_on;

  // Bar index 0..7 gives white, yellow, cyan, green, magenta, red, blue, black.
  assign bar_full    = h / BAR_W;
  assign bar         = bar_full[2:0];
  assign pattern_rgb = {{8{~bar[1]}}, {8{~bar[2]}}, {8{~bar[0]}}};
  assign use_pattern = pattern_on;
  assign unused_bits = ^{hold[23:16], hold[8], hold[0], bar_full, pattern_rgb[16],
                         pattern_rgb[8], pattern_rgb[0]};

  // pattern_sel is latched in the sync-word slot and holds for the whole pixel.
  always_ff @(posedge vdc_clk) begin
    if (vdc_rst) pattern_on <= 1'b0;
    else if (phase == 2'd0) pattern_on <= pattern_sel;
  end
`else
  assign pattern_rgb = 24'h000000;
  assign use_pattern = 1'b0;
  assign unused_bits = ^{hold[23:16], hold[8], hold[0], pattern_rgb};
`endif

  // Raster counters: phase steps every word, and h/v step at the end of each pixel.
  always_ff @(posedge vdc_clk) begin
    if (vdc_rst) begin
      phase <= 2'd0;
      h     <= '0;
      v     <= '0;
    end else begin
      phase <= phase + 2'd1;
      if (phase == 2'd3) begin
        if (h == H_LAST) begin
          h <= '0;
          v <= (v == V_LAST) ? '0 : v + VW'(1);
        end else begin
          h <= h + HW'(1);
        end
      end
    end
  end

  // Output word registers. The red word comes straight from in_rgb at capture, so there is no extra latency.
  always_ff @(posedge vdc_clk) begin
    if (vdc_rst) begin
      vdc_dsync <= 1'b1;
      vdc_bus   <= 7'h0F;
      in_ready  <= 1'b0;
      sof       <= 1'b0;
      underrun  <= 1'b0;
      hold      <= 24'h000000;
    end else begin
      in_ready <= 1'b0;
      sof      <= 1'b0;
      case (phase)
        2'd0: begin
          vdc_dsync <= 1'b0;
          vdc_bus   <= sync_word;
`ifdef VDC_TEST_PATTERN_EN
          in_ready  <= active && !pattern_sel;
`else
          in_ready  <= active;
`endif
          sof       <= (h == '0) && (v == '0);
        end
        2'd1: begin
          vdc_dsync <= 1'b1;
          if (!active) begin
            vdc_bus <= 7'h00;
            hold    <= 24'h000000;
          end else if (use_pattern) begin
            vdc_bus <= pattern_rgb[23:17];
            hold    <= pattern_rgb;
          end else if (in_valid) begin
            vdc_bus <= in_rgb[23:17];
            hold    <= in_rgb;
          end else begin
            vdc_bus  <= 7'h00;
            hold     <= 24'h000000;
            underrun <= 1'b1;
          end
        end
        2'd2: begin
          vdc_dsync <= 1'b1;
          vdc_bus   <= hold[15:9];
        end
        default: begin
          vdc_dsync <= 1'b1;
          vdc_bus   <= hold[7:1];
        end
      endcase
    end
  end

endmodule
`default_nettype wire
